// File: rtl/wptr_full_sync.sv
// -----------------------------------------------------------------------------
// wptr_full_sync
//
// Write-side pointer and flag generator for a dual-clock FIFO. Keeps the
// binary and Gray write pointers (ADDR_WIDTH+1 bits, top bit is the wrap bit),
// brings the read-side Gray pointer into i_wclk through a flop chain, and
// derives full, almost-full, fill level and a sticky overflow flag from it.
//
// Ports:
//   i_wclk         write clock
//   i_wrst_n       asynchronous active-low reset
//   i_winc         write request
//   i_rptr_gray    Gray read pointer from the read clock domain
//   i_afull_level  almost-full threshold in words (quasi-static)
//   i_oflow_clr    clears o_woverflow (a same-edge set takes priority)
//   o_wen          RAM write enable = i_winc & ~o_wfull
//   o_waddr        RAM write address (low bits of the binary pointer)
//   o_wptr         registered Gray write pointer for the read-side synchroniser
//   o_wfull        FIFO full
//   o_wafull       fill level >= i_afull_level
//   o_wlevel       words held, as seen from the write side
//   o_woverflow    sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module wptr_full_sync #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_wclk,
   input  logic                  i_wrst_n,
   input  logic                  i_winc,
   input  logic [ADDR_WIDTH:0]   i_rptr_gray,
   input  logic [ADDR_WIDTH:0]   i_afull_level,
   input  logic                  i_oflow_clr,
   output logic                  o_wen,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [ADDR_WIDTH:0]   o_wptr,
   output logic                  o_wfull,
   output logic                  o_wafull,
   output logic [ADDR_WIDTH:0]   o_wlevel,
   output logic                  o_woverflow
);

   localparam int PW = ADDR_WIDTH + 1;

   // Binary to reflected Gray code.
   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Reflected Gray code to binary: each binary bit is the XOR of all Gray
   // bits at and above it.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wbin_r;
   logic [PW-1:0] wgray_r;
   logic          wfull_r;
   logic          wafull_r;
   logic [PW-1:0] wlevel_r;
   logic          woverflow_r;
   logic [PW-1:0] sync_r [SYNC_STAGES];

   logic          winc_ok_s;
   logic [PW-1:0] wbnext_s;
   logic [PW-1:0] wgnext_s;
   logic [PW-1:0] rq_s;
   logic [PW-1:0] rbin_sync_s;
   logic [PW-1:0] full_cmp_s;
   logic          wfull_next_s;
   logic [PW-1:0] level_next_s;
   logic          wafull_next_s;
   logic          woverflow_next_s;

   // Next-state pointer arithmetic and flag conditions.
   always_comb begin
      winc_ok_s        = 1'b0;
      wbnext_s         = {PW{1'b0}};
      wgnext_s         = {PW{1'b0}};
      rq_s             = {PW{1'b0}};
      rbin_sync_s      = {PW{1'b0}};
      full_cmp_s       = {PW{1'b0}};
      wfull_next_s     = 1'b0;
      level_next_s     = {PW{1'b0}};
      wafull_next_s    = 1'b0;
      woverflow_next_s = 1'b0;

      winc_ok_s   = i_winc & ~wfull_r;
      wbnext_s    = wbin_r + {{ADDR_WIDTH{1'b0}}, winc_ok_s};
      wgnext_s    = bin2gray(wbnext_s);
      rq_s        = sync_r[SYNC_STAGES-1];
      rbin_sync_s = gray2bin(rq_s);

      // In Gray code, "write is exactly one lap ahead" means the top two
      // bits differ from the read pointer and the rest are equal.
      full_cmp_s   = {~rq_s[PW-1:PW-2], rq_s[PW-3:0]};
      wfull_next_s = (wgnext_s == full_cmp_s);

      level_next_s  = wbnext_s - rbin_sync_s;
      wafull_next_s = (level_next_s >= i_afull_level);

      // Set has priority over clear.
      if (i_winc && wfull_r) begin
         woverflow_next_s = 1'b1;
      end else begin
         woverflow_next_s = woverflow_r & ~i_oflow_clr;
      end
   end

   // Read-pointer synchroniser chain into the write clock domain.
   always_ff @(posedge i_wclk or negedge i_wrst_n) begin
      if (!i_wrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {PW{1'b0}};
         end
      end else begin
         sync_r[0] <= i_rptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Write pointers and all registered flags.
   always_ff @(posedge i_wclk or negedge i_wrst_n) begin
      if (!i_wrst_n) begin
         wbin_r      <= {PW{1'b0}};
         wgray_r     <= {PW{1'b0}};
         wfull_r     <= 1'b0;
         // With a zero threshold an empty FIFO is already "almost full".
         wafull_r    <= (i_afull_level == {PW{1'b0}});
         wlevel_r    <= {PW{1'b0}};
         woverflow_r <= 1'b0;
      end else begin
         wbin_r      <= wbnext_s;
         wgray_r     <= wgnext_s;
         wfull_r     <= wfull_next_s;
         wafull_r    <= wafull_next_s;
         wlevel_r    <= level_next_s;
         woverflow_r <= woverflow_next_s;
      end
   end

   assign o_wen       = i_winc & ~wfull_r;
   assign o_waddr     = wbin_r[ADDR_WIDTH-1:0];
   assign o_wptr      = wgray_r;
   assign o_wfull     = wfull_r;
   assign o_wafull    = wafull_r;
   assign o_wlevel    = wlevel_r;
   assign o_woverflow = woverflow_r;

endmodule
